// File: rtl/ocl_axil_regfile_if.sv
// AXI-Lite slave bundle for the OCL register file (signal names follow the shell's s_* naming).
interface ocl_axil_regfile_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              s_awvalid;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awready;
  logic              s_wvalid;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_wready;
  logic              s_bvalid;
  logic [1:0]        s_bresp;
  logic              s_bready;
  logic              s_arvalid;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arready;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rready;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp
  );
endinterface

// File: rtl/ocl_axil_regfile.sv
// Parametrised AXI-Lite register file for the OCL BAR0 path: byte-strobed writes,
// independent AW/W capture, read-only mask and SLVERR on unmapped/RO accesses.
module ocl_axil_regfile #(
  parameter int unsigned              ADDR_W        = 32,
  parameter int unsigned              NUM_REGS      = 16,
  parameter logic [ADDR_W-1:0]        BASE_ADDR     = ADDR_W'(32'h0000_0500),
  parameter logic [NUM_REGS-1:0]      RO_MASK       = '0,
  parameter logic [32*NUM_REGS-1:0]   RESET_VALUE   = '0,
  parameter logic [31:0]              UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main,
  ocl_axil_regfile_if.slave        axil,
  output logic [32*NUM_REGS-1:0]   reg_q,
  input  logic [32*NUM_REGS-1:0]   ro_in,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int unsigned IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = (addr - BASE_ADDR) >> 2;
    return (addr >= BASE_ADDR) && (word < ADDR_W'(NUM_REGS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word;
    word = (addr - BASE_ADDR) >> 2;
    return IDX_W'(word);
  endfunction

  logic [31:0]         r_regs [NUM_REGS];
  logic [31:0]         w_ro   [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_pulse;

  logic                r_aw_held;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic                r_w_held;
  logic [31:0]         r_w_data;
  logic [3:0]          r_w_strb;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [1:0]          r_bresp;

  logic                r_ar_held;
  logic [ADDR_W-1:0]   r_ar_addr;
  logic                r_arready;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic [1:0]          r_rresp;

  logic                w_aw_hs, w_w_hs, w_b_hs, w_commit;
  logic                w_aw_held_n, w_w_held_n, w_bvalid_n;
  logic                w_wr_ok;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [NUM_REGS-1:0] w_wr_hit;
  logic                w_ar_hs, w_r_hs, w_rvalid_n;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [31:0]         w_rd_data;
  logic [1:0]          w_rd_resp;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_ro[g]            = ro_in[32*g +: 32];
    assign reg_q[32*g +: 32]  = r_regs[g];
  end

  assign wr_pulse       = r_wr_pulse;
  assign axil.s_awready = r_awready;
  assign axil.s_wready  = r_wready;
  assign axil.s_bvalid  = r_bvalid;
  assign axil.s_bresp   = r_bresp;
  assign axil.s_arready = r_arready;
  assign axil.s_rvalid  = r_rvalid;
  assign axil.s_rdata   = r_rdata;
  assign axil.s_rresp   = r_rresp;

  // Write-side handshakes and next-state of the holding/response flags
  assign w_aw_hs     = axil.s_awvalid && r_awready;
  assign w_w_hs      = axil.s_wvalid && r_wready;
  assign w_b_hs      = r_bvalid && axil.s_bready;
  assign w_commit    = r_aw_held && r_w_held;
  assign w_aw_held_n = !w_commit && (r_aw_held || w_aw_hs);
  assign w_w_held_n  = !w_commit && (r_w_held || w_w_hs);
  assign w_bvalid_n  = w_commit || (r_bvalid && !w_b_hs);

  assign w_wr_idx = addr_index(r_aw_addr);
  assign w_wr_ok  = addr_mapped(r_aw_addr) && !RO_MASK[w_wr_idx];

  always_comb begin
    w_wr_hit = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_wr_hit[i] = w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_aw_held <= w_aw_held_n;
      r_w_held  <= w_w_held_n;
      if (w_aw_hs) r_aw_addr <= axil.s_awaddr;
      if (w_w_hs) begin
        r_w_data <= axil.s_wdata;
        r_w_strb <= axil.s_wstrb;
      end
      r_awready <= !w_aw_held_n && !w_bvalid_n;
      r_wready  <= !w_w_held_n && !w_bvalid_n;
      r_bvalid  <= w_bvalid_n;
      if (w_commit) begin
        r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (w_b_hs) begin
        r_bresp <= RESP_OKAY;
      end
    end
  end

  // Register storage; RO entries keep their reset contents and are never written
  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VALUE[32*i +: 32];
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wr_hit;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_wr_hit[i]) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (r_w_strb[b]) r_regs[i][8*b +: 8] <= r_w_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read path: one outstanding AR, data sampled the cycle after acceptance
  assign w_ar_hs    = axil.s_arvalid && r_arready;
  assign w_r_hs     = r_rvalid && axil.s_rready;
  assign w_rvalid_n = r_ar_held || (r_rvalid && !w_r_hs);
  assign w_rd_idx   = addr_index(r_ar_addr);

  always_comb begin
    w_rd_data = UNMAPPED_DATA;
    w_rd_resp = RESP_SLVERR;
    if (addr_mapped(r_ar_addr)) begin
      w_rd_resp = RESP_OKAY;
      w_rd_data = RO_MASK[w_rd_idx] ? w_ro[w_rd_idx] : r_regs[w_rd_idx];
    end
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      r_ar_held <= 1'b0;
      r_ar_addr <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_ar_held <= w_ar_hs;
      if (w_ar_hs) r_ar_addr <= axil.s_araddr;
      r_arready <= !w_ar_hs && !w_rvalid_n;
      r_rvalid  <= w_rvalid_n;
      if (r_ar_held) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end else if (w_r_hs) begin
        r_rdata <= '0;
        r_rresp <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_ocl_axil_regfile.sv
// Randomised self-checking bench for ocl_axil_regfile against an array-based register model.
module tb_ocl_axil_regfile;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned QW       = 32 * NUM_REGS;
  localparam logic [31:0] BASE     = 32'h0000_0500;
  localparam logic [NUM_REGS-1:0] RO_MASK = 16'h0004;

  function automatic logic [QW-1:0] mk_reset();
    logic [QW-1:0] v;
    for (int i = 0; i < NUM_REGS; i++)
      v[32*i +: 32] = (i == 1) ? 32'hFFFF_FFFF : 32'h0101_0101 * 32'(i);
    return v;
  endfunction
  localparam logic [QW-1:0] RST_VAL = mk_reset();

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [QW-1:0]       reg_q;
  logic [QW-1:0]       ro_in;
  logic [NUM_REGS-1:0] wr_pulse;

  ocl_axil_regfile_if #(.ADDR_W(ADDR_W)) axil();

  ocl_axil_regfile #(
    .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE), .RO_MASK(RO_MASK),
    .RESET_VALUE(RST_VAL), .UNMAPPED_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk_main_a0(clk), .rst_main(rst), .axil(axil),
    .reg_q(reg_q), .ro_in(ro_in), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_regs [NUM_REGS];
  logic [31:0] m_ro   [NUM_REGS];

  task automatic check_eq(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_mapped(input logic [31:0] addr);
    return (addr >= BASE) && (((addr - BASE) >> 2) < NUM_REGS);
  endfunction

  function automatic logic [QW-1:0] model_q();
    logic [QW-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = RST_VAL[32*i +: 32];
  endtask

  // Full write: W leads AW by w_lead cycles (negative = AW first); B held off for hold cycles
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int hold);
    bit aw_done, w_done, aw_go, w_go;
    int k, aw_at, w_at, idx;
    logic [1:0] exp_resp;
    logic [NUM_REGS-1:0] exp_pulse;
    aw_done = 0; w_done = 0; k = 0;
    aw_at = (w_lead > 0) ? w_lead : 0;
    w_at  = (w_lead < 0) ? -w_lead : 0;
    exp_pulse = '0;
    exp_resp  = 2'b10;
    if (model_mapped(addr)) begin
      idx = int'((addr - BASE) >> 2);
      if (!RO_MASK[idx]) begin
        exp_resp = 2'b00;
        exp_pulse[idx] = 1'b1;
        for (int b = 0; b < 4; b++) if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
    while (!(aw_done && w_done)) begin
      axil.s_awvalid = !aw_done && (k >= aw_at);
      axil.s_awaddr  = addr;
      axil.s_wvalid  = !w_done && (k >= w_at);
      axil.s_wdata   = data;
      axil.s_wstrb   = strb;
      if (w_done && !aw_done) check_eq("wready_low_while_w_held", 1'(axil.s_wready), 0);
      aw_go = axil.s_awvalid && axil.s_awready;
      w_go  = axil.s_wvalid && axil.s_wready;
      @(negedge clk);
      k++;
      if (aw_go) aw_done = 1;
      if (w_go)  w_done = 1;
      if (k > 60) begin
        check_eq("wr_handshake_timeout", 0, 1);
        aw_done = 1; w_done = 1;
      end
    end
    axil.s_awvalid = 0;
    axil.s_wvalid  = 0;
    check_eq("bvalid_not_early", 1'(axil.s_bvalid), 0);
    check_eq("pulse_not_early", wr_pulse, 0);
    @(negedge clk);
    check_eq("bvalid_c2", 1'(axil.s_bvalid), 1);
    check_eq("bresp", axil.s_bresp, exp_resp);
    check_eq("wr_pulse", wr_pulse, exp_pulse);
    check_eq("reg_q_after_write", reg_q, model_q());
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("bvalid_hold", 1'(axil.s_bvalid), 1);
      check_eq("bresp_hold", axil.s_bresp, exp_resp);
      check_eq("awready_low_hold", 1'(axil.s_awready), 0);
      check_eq("wready_low_hold", 1'(axil.s_wready), 0);
      check_eq("pulse_one_cycle", wr_pulse, 0);
    end
    axil.s_bready = 1;
    @(negedge clk);
    axil.s_bready = 0;
    check_eq("bvalid_cleared", 1'(axil.s_bvalid), 0);
    check_eq("awready_after_b", 1'(axil.s_awready), 1);
    check_eq("wready_after_b", 1'(axil.s_wready), 1);
    check_eq("pulse_after_b", wr_pulse, 0);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int hold);
    bit go;
    int k, idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = 32'hDEAD_BEEF;
    exp_resp = 2'b10;
    if (model_mapped(addr)) begin
      idx = int'((addr - BASE) >> 2);
      exp_resp = 2'b00;
      exp_data = RO_MASK[idx] ? m_ro[idx] : m_regs[idx];
    end
    go = 0; k = 0;
    while (!go) begin
      axil.s_arvalid = 1;
      axil.s_araddr  = addr;
      go = axil.s_arready;
      @(negedge clk);
      k++;
      if (!go && k > 60) begin
        check_eq("ar_handshake_timeout", 0, 1);
        go = 1;
      end
    end
    axil.s_arvalid = 0;
    check_eq("rvalid_not_early", 1'(axil.s_rvalid), 0);
    @(negedge clk);
    check_eq("rvalid_c2", 1'(axil.s_rvalid), 1);
    check_eq("rdata", axil.s_rdata, exp_data);
    check_eq("rresp", axil.s_rresp, exp_resp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("rvalid_hold", 1'(axil.s_rvalid), 1);
      check_eq("rdata_hold", axil.s_rdata, exp_data);
      check_eq("rresp_hold", axil.s_rresp, exp_resp);
      check_eq("arready_low_hold", 1'(axil.s_arready), 0);
    end
    axil.s_rready = 1;
    @(negedge clk);
    axil.s_rready = 0;
    check_eq("rvalid_cleared", 1'(axil.s_rvalid), 0);
    check_eq("rdata_cleared", axil.s_rdata, 0);
    check_eq("rresp_cleared", axil.s_rresp, 0);
    check_eq("arready_after_r", 1'(axil.s_arready), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_awready"}, 1'(axil.s_awready), 0);
    check_eq({tag, "_wready"},  1'(axil.s_wready), 0);
    check_eq({tag, "_arready"}, 1'(axil.s_arready), 0);
    check_eq({tag, "_bvalid"},  1'(axil.s_bvalid), 0);
    check_eq({tag, "_rvalid"},  1'(axil.s_rvalid), 0);
    check_eq({tag, "_bresp"},   axil.s_bresp, 0);
    check_eq({tag, "_rresp"},   axil.s_rresp, 0);
    check_eq({tag, "_rdata"},   axil.s_rdata, 0);
    check_eq({tag, "_pulse"},   wr_pulse, 0);
    check_eq({tag, "_reg_q"},   reg_q, RST_VAL);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old3, new3, a, d;
    axil.s_awvalid = 0; axil.s_awaddr = '0; axil.s_wvalid = 0; axil.s_wdata = '0;
    axil.s_wstrb = '0; axil.s_bready = 0; axil.s_arvalid = 0; axil.s_araddr = '0;
    axil.s_rready = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      m_ro[i] = (i == 2) ? 32'h1234_5678 : $urandom;
      ro_in[32*i +: 32] = m_ro[i];
    end
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);
    check_eq("awready_first", 1'(axil.s_awready), 1);
    check_eq("wready_first", 1'(axil.s_wready), 1);
    check_eq("arready_first", 1'(axil.s_arready), 1);

    // Basic aligned write/read of register 0
    write_txn(32'h500, 32'hA5A5_5A5A, 4'hF, 0, 0);
    check_eq("reg0_value", reg_q[31:0], 32'hA5A5_5A5A);
    read_txn(32'h500, 0);

    // W three cycles ahead of AW, partial strobe onto a preloaded register
    write_txn(32'h504, 32'h1122_3344, 4'h5, 3, 0);
    check_eq("reg1_value", reg_q[63:32], 32'hFF22_FF44);

    // Unmapped and read-only accesses
    write_txn(32'h500 + 4 * NUM_REGS, 32'hCAFE_F00D, 4'hF, 0, 0);
    read_txn(32'h4FC, 0);
    write_txn(32'h508, 32'h0BAD_0BAD, 4'hF, -1, 0);
    read_txn(32'h508, 0);
    write_txn(32'h50C, 32'h7777_7777, 4'h0, 0, 0);

    // Back-pressure on both channels at once, then immediate follow-up write
    fork
      write_txn(32'h510, 32'h5555_AAAA, 4'hF, 0, 10);
      read_txn(32'h514, 10);
    join
    write_txn(32'h518, 32'h0F0F_0F0F, 4'hC, 0, 0);

    // Same-cycle commit and read sample on register 3 return the old value
    old3 = m_regs[3];
    new3 = 32'h3C3C_C3C3;
    axil.s_awvalid = 1; axil.s_awaddr = 32'h50C;
    axil.s_wvalid = 1; axil.s_wdata = new3; axil.s_wstrb = 4'hF;
    axil.s_arvalid = 1; axil.s_araddr = 32'h50C;
    @(negedge clk);
    axil.s_awvalid = 0; axil.s_wvalid = 0; axil.s_arvalid = 0;
    @(negedge clk);
    m_regs[3] = new3;
    check_eq("collision_rvalid", 1'(axil.s_rvalid), 1);
    check_eq("collision_rdata_old", axil.s_rdata, old3);
    check_eq("collision_reg_q_new", reg_q, model_q());
    axil.s_bready = 1; axil.s_rready = 1;
    @(negedge clk);
    axil.s_bready = 0; axil.s_rready = 0;

    // Randomised traffic
    for (int n = 0; n < 60; n++) begin
      a = 32'h4F0 + $urandom_range(0, 32'h60);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        write_txn(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)) - 3,
                  int'($urandom_range(0, 3)));
      end else begin
        read_txn(a, int'($urandom_range(0, 2)));
      end
    end

    // Reset between AW capture and W: nothing may commit afterwards
    axil.s_awvalid = 1; axil.s_awaddr = 32'h500;
    check_eq("aw_ready_before_rst", 1'(axil.s_awready), 1);
    @(negedge clk);
    axil.s_awvalid = 0;
    rst = 1;
    @(negedge clk);
    model_reset();
    check_reset_outputs("midrst");
    rst = 0;
    @(negedge clk);
    check_eq("wready_after_midrst", 1'(axil.s_wready), 1);
    axil.s_wvalid = 1; axil.s_wdata = 32'h9999_9999; axil.s_wstrb = 4'hF;
    @(negedge clk);
    axil.s_wvalid = 0;
    for (int i = 0; i < 6; i++) begin
      check_eq("orphan_w_no_b", 1'(axil.s_bvalid), 0);
      check_eq("orphan_w_no_pulse", wr_pulse, 0);
      @(negedge clk);
    end
    check_eq("orphan_w_reg_q", reg_q, RST_VAL);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
